// File: rtl/apb_gpi_irq.sv
// APB3 general-purpose input port with synchroniser, per-pin edge detect and sticky interrupt status.
// Optional per-pin debounce filter is built when GPI_DEBOUNCE_EN is defined.
`timescale 1ns/1ps
module apb_gpi_irq #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic [4:0]       PADDR,
    input  logic             PWRITE,
    input  logic             PENABLE,
    input  logic             PSEL,
    input  logic [31:0]      PWDATA,
    output logic [31:0]      PRDATA,
    output logic             PREADY,
    input  logic [WIDTH-1:0] gpi,
    output logic             irq
);
    localparam logic [2:0] A_CR   = 3'd0;
    localparam logic [2:0] A_IDR  = 3'd1;
    localparam logic [2:0] A_IER  = 3'd2;
    localparam logic [2:0] A_RISE = 3'd3;
    localparam logic [2:0] A_FALL = 3'd4;
    localparam logic [2:0] A_ISR  = 3'd5;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] w_sync_q;
    logic [WIDTH-1:0] w_din;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_cr;
    logic [WIDTH-1:0] r_ier;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [WIDTH-1:0] r_isr;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_wdata;
    logic [31:0]      w_rdata;
    logic [31:0]      r_prdata;
    logic             r_pready;
    logic             w_xfer;
    logic             w_wr;
    logic             w_unused;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], gpi};
        end
    end

    assign w_sync_q = r_sync[SYNC_STAGES-1];

`ifdef GPI_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic [WIDTH-1:0][CW-1:0] r_deb_cnt;
    logic [WIDTH-1:0]         r_din;

    // din follows sync_q only once the new level has persisted DEB_CYCLES edges
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_deb_cnt <= '0;
            r_din     <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_sync_q[i] == r_din[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_din[i]     <= w_sync_q[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign w_din = r_din;
`else
    assign w_din = w_sync_q;
`endif

    assign w_xfer  = PSEL & PENABLE & ~r_pready;
    assign w_wr    = w_xfer & PWRITE;
    assign w_wdata = PWDATA[WIDTH-1:0];
    assign w_clr   = (w_wr && (PADDR[4:2] == A_ISR)) ? w_wdata : '0;
    assign w_set   = r_cr & ((w_din & ~r_prev & r_rise) | (~w_din & r_prev & r_fall));

    always_comb begin
        w_rdata = '0;
        case (PADDR[4:2])
            A_CR:    w_rdata[WIDTH-1:0] = r_cr;
            A_IDR:   w_rdata[WIDTH-1:0] = w_din & r_cr;
            A_IER:   w_rdata[WIDTH-1:0] = r_ier;
            A_RISE:  w_rdata[WIDTH-1:0] = r_rise;
            A_FALL:  w_rdata[WIDTH-1:0] = r_fall;
            A_ISR:   w_rdata[WIDTH-1:0] = r_isr;
            default: w_rdata = '0;
        endcase
    end

    // Set term is OR-ed after the W1C mask so a simultaneous edge always wins
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_prev   <= '0;
            r_cr     <= '0;
            r_ier    <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
            r_isr    <= '0;
            r_prdata <= '0;
            r_pready <= 1'b0;
        end else begin
            r_pready <= w_xfer;
            r_prev   <= w_din;
            r_isr    <= (r_isr & ~w_clr) | w_set;
            if (w_xfer && !PWRITE) begin
                r_prdata <= w_rdata;
            end
            if (w_wr) begin
                case (PADDR[4:2])
                    A_CR:    r_cr   <= w_wdata;
                    A_IER:   r_ier  <= w_wdata;
                    A_RISE:  r_rise <= w_wdata;
                    A_FALL:  r_fall <= w_wdata;
                    default: ;
                endcase
            end
        end
    end

    assign PRDATA = r_prdata;
    assign PREADY = r_pready;
    assign irq    = |(r_isr & r_ier);

    assign w_unused = ^{PADDR[1:0], PWDATA, 1'(DEB_CYCLES)};
endmodule

// File: tb/tb_apb_gpi_irq.sv
// Scoreboard bench for apb_gpi_irq: APB reads queue their expected data, popped when PREADY completes.
`timescale 1ns/1ps
module tb_apb_gpi_irq;
    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int DEB_CYCLES  = 4;
`ifdef GPI_DEBOUNCE_EN
    localparam int DEB_LAT = DEB_CYCLES;
`else
    localparam int DEB_LAT = 0;
`endif
    // Edges from a gpi change (made just after an edge) to the edge that sets ISR
    localparam int LAT = SYNC_STAGES + 1 + DEB_LAT;
    localparam logic [31:0] MASK = (WIDTH >= 32) ? 32'hFFFF_FFFF : ((32'd1 << WIDTH) - 32'd1);

    localparam logic [4:0] A_CR   = 5'h00;
    localparam logic [4:0] A_IDR  = 5'h04;
    localparam logic [4:0] A_IER  = 5'h08;
    localparam logic [4:0] A_RISE = 5'h0C;
    localparam logic [4:0] A_FALL = 5'h10;
    localparam logic [4:0] A_ISR  = 5'h14;

    logic             PCLK = 1'b0;
    logic             PRESET;
    logic [4:0]       PADDR;
    logic             PWRITE;
    logic             PENABLE;
    logic             PSEL;
    logic [31:0]      PWDATA;
    logic [31:0]      PRDATA;
    logic             PREADY;
    logic [WIDTH-1:0] gpi;
    logic             irq;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] sb_exp[$];
    string       sb_tag[$];

    apb_gpi_irq #(
        .WIDTH(WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .PCLK(PCLK),
        .PRESET(PRESET),
        .PADDR(PADDR),
        .PWRITE(PWRITE),
        .PENABLE(PENABLE),
        .PSEL(PSEL),
        .PWDATA(PWDATA),
        .PRDATA(PRDATA),
        .PREADY(PREADY),
        .gpi(gpi),
        .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    // Called 1ns after an edge; returns 1ns after the edge that drops PREADY
    task automatic apb_access(input logic [4:0] a, input logic wr, input logic [31:0] wd,
                              input string tag);
        logic        ok;
        int          waited;
        logic [31:0] e;
        string       t;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = a;
        PWDATA  = wd;
        tick(1);
        PENABLE = 1'b1;
        ok      = 1'b0;
        waited  = 0;
        while (!ok && waited < 8) begin
            tick(1);
            waited++;
            ok = PREADY;
        end
        if (!ok) check({tag, "_pready"}, {31'd0, PREADY}, 32'd1);
        else     check({tag, "_wait"}, waited, 32'd1);
        if (!wr) begin
            e = sb_exp.pop_front();
            t = sb_tag.pop_front();
            if (ok) check(t, PRDATA, e);
        end
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        tick(1);
        check({tag, "_pready_pulse"}, {31'd0, PREADY}, 32'd0);
    endtask

    task automatic apb_write(input logic [4:0] a, input logic [31:0] d, input string tag);
        apb_access(a, 1'b1, d, tag);
    endtask

    task automatic apb_read(input logic [4:0] a, input logic [31:0] exp, input string tag);
        sb_exp.push_back(exp);
        sb_tag.push_back(tag);
        apb_access(a, 1'b0, 32'd0, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESET  = 1'b1;
        PADDR   = '0;
        PWRITE  = 1'b0;
        PENABLE = 1'b0;
        PSEL    = 1'b0;
        PWDATA  = '0;
        gpi     = '0;
        tick(3);
        check("rst_pready", {31'd0, PREADY}, 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        PRESET = 1'b0;
        tick(1);
        for (int a = 0; a < 8; a++) apb_read(5'(a * 4), 32'd0, $sformatf("init_rd_%0d", a));

        // Read/write, IDR masking by CR, upper bits ignored
        apb_write(A_CR, 32'h0000_000F, "wr_cr");
        apb_read(A_CR, 32'h0000_000F, "rd_cr");
        gpi = 8'hA5;
        tick(SYNC_STAGES + 2 + DEB_LAT);
        apb_read(A_IDR, 32'h0000_0005 & MASK, "rd_idr");
        apb_write(A_IER, 32'h1234_56C3, "wr_ier_wide");
        apb_read(A_IER, 32'h1234_56C3 & MASK, "rd_ier_wide");
        apb_write(A_IER, 32'd0, "wr_ier_0");

        // Rising edge latency
        gpi = '0;
        tick(LAT + 2);
        apb_write(A_CR, 32'h0000_00FF, "wr_cr_ff");
        apb_write(A_RISE, 32'h0000_0001, "wr_rise");
        apb_write(A_IER, 32'h0000_0001, "wr_ier");
        gpi[0] = 1'b1;
        tick(LAT - 1);
        check("irq_before_edge", {31'd0, irq}, 32'd0);
        tick(1);
        check("irq_at_edge", {31'd0, irq}, 32'd1);
        apb_read(A_ISR, 32'h0000_0001, "rd_isr_rise");

        // W1C committed on the same edge as a new falling-edge set
        apb_write(A_FALL, 32'h0000_0001, "wr_fall");
        gpi[0] = 1'b0;
        tick(LAT - 2);
        apb_write(A_ISR, 32'h0000_0001, "w1c_race");
        apb_read(A_ISR, 32'h0000_0001, "rd_isr_race");
        check("irq_race", {31'd0, irq}, 32'd1);
        apb_write(A_ISR, 32'h0000_0001, "w1c_clear");
        apb_read(A_ISR, 32'd0, "rd_isr_cleared");
        check("irq_cleared", {31'd0, irq}, 32'd0);

        // Pin enable and interrupt enable masking
        apb_write(A_FALL, 32'h0000_0008, "wr_fall3");
        apb_write(A_RISE, 32'h0000_0002, "wr_rise1");
        apb_write(A_IER, 32'h0000_0000, "wr_ier_off");
        apb_write(A_CR, 32'h0000_00F7, "wr_cr_f7");
        gpi[3] = 1'b1;
        tick(LAT + 2);
        gpi[3] = 1'b0;
        tick(LAT + 2);
        apb_read(A_ISR, 32'd0, "rd_isr_cr_masked");
        gpi[1] = 1'b1;
        tick(LAT + 2);
        check("irq_ier_masked", {31'd0, irq}, 32'd0);
        apb_read(A_ISR, 32'h0000_0002, "rd_isr_pin1");
        apb_write(A_IER, 32'h0000_0002, "wr_ier1");
        check("irq_ier_on", {31'd0, irq}, 32'd1);
        apb_write(A_ISR, 32'h0000_0000, "w1c_zero");
        apb_write(A_CR, 32'h0000_0000, "wr_cr_0");
        apb_read(A_ISR, 32'h0000_0002, "rd_isr_keep");
        apb_read(A_IDR, 32'd0, "rd_idr_disabled");
        apb_write(5'h1C, 32'hFFFF_FFFF, "wr_unmapped");
        apb_read(5'h1C, 32'd0, "rd_1c");
        apb_read(5'h18, 32'd0, "rd_18");

`ifdef GPI_DEBOUNCE_EN
        // Short glitch rejected, long pulse accepted
        apb_write(A_ISR, 32'h0000_0002, "w1c_pin1");
        gpi[1] = 1'b0;
        tick(LAT + 4);
        apb_write(A_CR, 32'h0000_00FF, "wr_cr_deb");
        gpi[1] = 1'b1;
        tick(DEB_CYCLES - 1);
        gpi[1] = 1'b0;
        tick(LAT + 4);
        apb_read(A_IDR, 32'd0, "rd_idr_glitch");
        apb_read(A_ISR, 32'd0, "rd_isr_glitch");
        gpi[1] = 1'b1;
        tick(DEB_CYCLES + 1);
        gpi[1] = 1'b0;
        tick(2);
        apb_read(A_ISR, 32'h0000_0002, "rd_isr_pulse");
        tick(LAT + 4);
`endif

        // Reset in the access phase of a write
        apb_read(A_ISR, 32'h0000_0002, "rd_isr_pre_rst");
        check("irq_pre_rst", {31'd0, irq}, 32'd1);
        PSEL    = 1'b1;
        PWRITE  = 1'b1;
        PADDR   = A_CR;
        PWDATA  = 32'h0000_00FF;
        PENABLE = 1'b0;
        tick(1);
        PENABLE = 1'b1;
        #2;
        PRESET = 1'b1;
        #1;
        check("midrst_pready", {31'd0, PREADY}, 32'd0);
        check("midrst_prdata", PRDATA, 32'd0);
        check("midrst_irq", {31'd0, irq}, 32'd0);
        tick(1);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        tick(1);
        PRESET = 1'b0;
        tick(1);
        check("post_rst_pready", {31'd0, PREADY}, 32'd0);
        for (int a = 0; a < 8; a++) apb_read(5'(a * 4), 32'd0, $sformatf("post_rst_rd_%0d", a));
        check("post_rst_irq", {31'd0, irq}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
